deserializer_frame_ctrl: RTL and testbench
==========================================

# deserializer_frame_ctrl

Frame sequencer for the receive deserializer. It tracks 62-bit descrambled words against start-of-frame markers and drives the `frame_state` / `frame_tail_flag` sequence that tells the deserializer where each word lands in the 1568-bit frame. A frame is 26 words: FRAME1..FRAME25 carry 62 bits each, and FRAME_TAIL carries 18 bits. The block sits between the descrambler/alignment logic and the deserializer, and also reports frame errors and completed-frame counts.

## Interface
- `CNT_W`, 16: width of the completed-frame counter.
- `WDOG_LIMIT`, 64: stall-watchdog threshold in cycles. Used only when `FRAME_CTRL_WATCHDOG_EN` is defined. Legal range is 2..2^16−1.

Ports:
- `clk_390p625M` in 1: system clock; all logic is on its rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `lock` in 1: alignment lock from the word aligner.
- `word_valid` in 1: a descrambled 62-bit word is present this cycle.
- `sof` in 1: start-of-frame marker; meaningful only when `word_valid`=1.
- `frame_state` out 5 (`frame_state_t`): slot of the word presented to the deserializer.
- `frame_tail_flag` out 1: high exactly when `frame_state`=FRAME_TAIL.
- `frame_err` out 1: one-cycle pulse when a frame is aborted.
- `frame_cnt` out `CNT_W`: completed frames, saturating.
- `busy` out 1: a frame is in progress (`pos`≠0).

## Operation
- Internal position `pos` runs 0..25. A value of 0 means no frame is open. Otherwise `pos` is the index of the last word issued.
- `frame_state` encoding: code = reflected Gray of the slot index.
  - IDLE=00000, FRAME1=00001, FRAME2=00011, …, FRAME25=10101, FRAME_TAIL=10111 (index 26).
  - The encoding is shared with the deserializer's `frame_state_t`.
- Per cycle, decisions are evaluated in priority order:
  1. `lock`=0: emit IDLE and set `pos`←0. Pulse `frame_err` if `pos`≠0. This dominates `sof` and `word_valid`.
  2. `word_valid`=0: emit IDLE and hold `pos`. This is a stall; the deserializer holds its buffer.
  3. `sof`=1: emit FRAME1 and set `pos`←1. Pulse `frame_err` if `pos`≠0 (truncated frame, resynchronised to the new frame).
  4. `pos`=0 without `sof`: emit IDLE; the word is discarded.
  5. `pos` in 1..24: emit code for `pos`+1 and set `pos`←`pos`+1.
  6. `pos`=25: emit FRAME_TAIL, assert `frame_tail_flag`, set `pos`←0, and increment `frame_cnt`, holding at all-ones once saturated.
- `sof` on the cycle after a tail (`pos`=0) is the normal back-to-back case; no error is raised.
- A stall never advances `pos`. Any number of stalls inside a frame is legal unless the watchdog is enabled.
- `busy` is the registered value of (next `pos`≠0).

## Timing
- All outputs are registered. Inputs sampled at edge N appear on the outputs after edge N.
- Upstream delays `unscrambled_data` by exactly one register stage so that data and `frame_state` are coincident at the deserializer.
- `frame_tail_flag` is a single-cycle pulse per frame. With no stalls, the minimum frame period is 26 cycles.
- `frame_err` is a single-cycle pulse. It coincides with the IDLE or FRAME1 emitted by the aborting event.
- Reset values:
  - `frame_state`=IDLE, `frame_tail_flag`=0, `frame_err`=0, `frame_cnt`=0, `busy`=0.
  - `pos`=0; watchdog counter =0.
- Reset asserted mid-frame clears everything immediately and asynchronously. No `frame_err` is generated.
- After reset release, the first word accepted is the first `sof` word with `lock`=1.

## Configuration
- `FRAME_CTRL_WATCHDOG_EN` defined:
  - A stall counter increments on each cycle with `pos`≠0, `lock`=1 and `word_valid`=0.
  - It clears on any accepted word or when `pos`=0.
  - When the count reaches `WDOG_LIMIT`: `pos`←0, pulse `frame_err`, emit IDLE, and clear the counter.
- `FRAME_CTRL_WATCHDOG_EN` undefined:
  - No counter is present, and the `WDOG_LIMIT` parameter is ignored.
  - Stalls are unbounded; a frame stays open until `sof`, `lock` loss or reset.

## Test plan
- Nominal frame: `lock`=1, then 26 consecutive valid words with `sof` on the first.
  - `frame_state` steps 00001…10101, 10111.
  - `frame_tail_flag` is high on the 26th output cycle only; `frame_cnt`=1; `frame_err` never pulses.
- Stalls: same frame with `word_valid`=0 for 3 cycles after word 10 and 1 cycle after word 25.
  - IDLE is emitted on the stall cycles; the sequence resumes at FRAME11 and then FRAME_TAIL.
  - `frame_cnt`=1, total 30 output cycles.
- Resync: `sof` on word 14 of an open frame.
  - `frame_err` pulses once with FRAME1 on the same cycle; the new frame completes normally with `frame_cnt`=1.
- Lock loss: `lock` drops at word 7 while `sof` is also high.
  - IDLE is emitted, `frame_err` pulses, `busy`=0.
  - Later words without `sof` emit IDLE until the next `sof`.
- Saturation and back-to-back: with `CNT_W`=2, run 5 back-to-back frames, each `sof` immediately following the tail.
  - `frame_cnt` reads 1, 2, 3, 3, 3; no errors.
- Watchdog (macro on, `WDOG_LIMIT`=4): stall 4 cycles after FRAME5 → `frame_err` pulses on the 4th stall cycle and `busy`=0.
  - With the macro off, the same stimulus resumes the frame at FRAME6.

Source files
------------

// File: rtl/deserializer_frame_ctrl.sv
// deserializer_frame_ctrl: walks 62-bit descrambled words through the 26 slots
// of a 1568-bit frame and drives the frame_state / frame_tail_flag sequence
// seen by the deserializer. It also flags aborted frames and counts completed ones.
// Optional feature: define FRAME_CTRL_WATCHDOG_EN to abort frames that stall
// for WDOG_LIMIT cycles.
module deserializer_frame_ctrl #(
   parameter int CNT_W      = 16,
   parameter int WDOG_LIMIT = 64
) (
   input  logic             clk_390p625M,
   input  logic             rst_n,
   input  logic             lock,
   input  logic             word_valid,
   input  logic             sof,
   output logic [4:0]       frame_state,
   output logic             frame_tail_flag,
   output logic             frame_err,
   output logic [CNT_W-1:0] frame_cnt,
   output logic             busy
);

   // Slot codes are the reflected Gray code of the slot index; the deserializer uses the same encoding
   typedef enum logic [4:0] {
      IDLE    = 5'b00000, FRAME1  = 5'b00001, FRAME2  = 5'b00011, FRAME3  = 5'b00010,
      FRAME4  = 5'b00110, FRAME5  = 5'b00111, FRAME6  = 5'b00101, FRAME7  = 5'b00100,
      FRAME8  = 5'b01100, FRAME9  = 5'b01101, FRAME10 = 5'b01111, FRAME11 = 5'b01110,
      FRAME12 = 5'b01010, FRAME13 = 5'b01011, FRAME14 = 5'b01001, FRAME15 = 5'b01000,
      FRAME16 = 5'b11000, FRAME17 = 5'b11001, FRAME18 = 5'b11011, FRAME19 = 5'b11010,
      FRAME20 = 5'b11110, FRAME21 = 5'b11111, FRAME22 = 5'b11101, FRAME23 = 5'b11100,
      FRAME24 = 5'b10100, FRAME25 = 5'b10101, FRAME_TAIL = 5'b10111
   } frame_state_t;

   localparam logic [4:0] LAST_FULL_POS = 5'd25;

   function automatic frame_state_t slot_code(input logic [4:0] idx);
      return frame_state_t'(idx ^ (idx >> 1));
   endfunction

   logic [4:0]   pos_q, pos_d;
   frame_state_t state_q, state_d;
   logic         tail_d, err_d, cnt_inc;

`ifdef FRAME_CTRL_WATCHDOG_EN
   localparam logic [15:0] WDOG_LAST = 16'(WDOG_LIMIT - 1);
   logic [15:0] wdog_q, wdog_d;
`else
   logic unused_wdog_limit;
   assign unused_wdog_limit = (WDOG_LIMIT != 0);
`endif

   // Next-slot decision: lock loss, stall, sof, discard, advance, tail, in that priority
   always_comb begin
      pos_d   = pos_q;
      state_d = IDLE;
      tail_d  = 1'b0;
      err_d   = 1'b0;
      cnt_inc = 1'b0;
`ifdef FRAME_CTRL_WATCHDOG_EN
      wdog_d  = '0;
`endif
      if (!lock) begin
         pos_d = '0;
         err_d = (pos_q != '0);
      end else if (!word_valid) begin
`ifdef FRAME_CTRL_WATCHDOG_EN
         if (pos_q != '0) begin
            if (wdog_q == WDOG_LAST) begin
               pos_d = '0;
               err_d = 1'b1;
            end else begin
               wdog_d = wdog_q + 16'd1;
            end
         end
`endif
      end else if (sof) begin
         state_d = FRAME1;
         pos_d   = 5'd1;
         err_d   = (pos_q != '0);
      end else if (pos_q != '0) begin
         if (pos_q < LAST_FULL_POS) begin
            pos_d   = pos_q + 5'd1;
            state_d = slot_code(pos_q + 5'd1);
         end else begin
            state_d = FRAME_TAIL;
            tail_d  = 1'b1;
            pos_d   = '0;
            cnt_inc = 1'b1;
         end
      end
   end

   // Register position and every output so the deserializer sees clean, aligned controls
   always_ff @(posedge clk_390p625M or negedge rst_n) begin
      if (!rst_n) begin
         pos_q           <= '0;
         state_q         <= IDLE;
         frame_tail_flag <= 1'b0;
         frame_err       <= 1'b0;
         frame_cnt       <= '0;
         busy            <= 1'b0;
      end else begin
         pos_q           <= pos_d;
         state_q         <= state_d;
         frame_tail_flag <= tail_d;
         frame_err       <= err_d;
         busy            <= (pos_d != '0);
         if (cnt_inc && !(&frame_cnt)) begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

`ifdef FRAME_CTRL_WATCHDOG_EN
   // Stall counter that bounds how long an open frame may wait for its next word
   always_ff @(posedge clk_390p625M or negedge rst_n) begin
      if (!rst_n) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_d;
      end
   end
`endif

   assign frame_state = state_q;

endmodule

// File: tb/tb_deserializer_frame_ctrl.sv
// Directed bench for deserializer_frame_ctrl: nominal frame, stalls, resync,
// lock loss, async reset, counter saturation, and stall-watchdog behaviour.
module tb_deserializer_frame_ctrl;

   localparam int CNT_W = 2;

   logic             clk_390p625M = 1'b0;
   logic             rst_n = 1'b0;
   logic             lock = 1'b0;
   logic             word_valid = 1'b0;
   logic             sof = 1'b0;
   logic [4:0]       frame_state;
   logic             frame_tail_flag;
   logic             frame_err;
   logic [CNT_W-1:0] frame_cnt;
   logic             busy;

   int checkCount = 0;
   int failCount  = 0;

   // Hand-written slot codes, index 0 = IDLE, 26 = FRAME_TAIL
   logic [4:0] codes [0:26] = '{
      5'b00000, 5'b00001, 5'b00011, 5'b00010, 5'b00110, 5'b00111, 5'b00101,
      5'b00100, 5'b01100, 5'b01101, 5'b01111, 5'b01110, 5'b01010, 5'b01011,
      5'b01001, 5'b01000, 5'b11000, 5'b11001, 5'b11011, 5'b11010, 5'b11110,
      5'b11111, 5'b11101, 5'b11100, 5'b10100, 5'b10101, 5'b10111 };

   // Free-running system clock
   always #5 clk_390p625M = ~clk_390p625M;

   deserializer_frame_ctrl #(.CNT_W(CNT_W), .WDOG_LIMIT(4)) dut (
      .clk_390p625M   (clk_390p625M),
      .rst_n          (rst_n),
      .lock           (lock),
      .word_valid     (word_valid),
      .sof            (sof),
      .frame_state    (frame_state),
      .frame_tail_flag(frame_tail_flag),
      .frame_err      (frame_err),
      .frame_cnt      (frame_cnt),
      .busy           (busy)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic l, input logic v, input logic s);
      @(negedge clk_390p625M);
      lock       = l;
      word_valid = v;
      sof        = s;
      @(posedge clk_390p625M);
      #1;
   endtask

   task automatic stepCheck(input string tag, input logic l, input logic v, input logic s,
                            input logic [4:0] expState, input logic expTail,
                            input logic expErr, input logic expBusy);
      applyStimulus(l, v, s);
      checkOutput({tag, " state"}, 32'(frame_state), 32'(expState));
      checkOutput({tag, " tail"},  32'(frame_tail_flag), 32'(expTail));
      checkOutput({tag, " err"},   32'(frame_err), 32'(expErr));
      checkOutput({tag, " busy"},  32'(busy), 32'(expBusy));
   endtask

   task automatic doReset();
      @(negedge clk_390p625M);
      rst_n      = 1'b0;
      lock       = 1'b1;
      word_valid = 1'b1;
      sof        = 1'b1;
      @(negedge clk_390p625M);
      checkOutput("rst state", 32'(frame_state), 32'd0);
      checkOutput("rst tail",  32'(frame_tail_flag), 32'd0);
      checkOutput("rst err",   32'(frame_err), 32'd0);
      checkOutput("rst cnt",   32'(frame_cnt), 32'd0);
      checkOutput("rst busy",  32'(busy), 32'd0);
      rst_n = 1'b1;
      lock = 1'b0; word_valid = 1'b0; sof = 1'b0;
   endtask

   // Safety net so the run always terminates
   initial begin
      #2_000_000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      // Nominal frame, then async reset in the middle of the next one
      doReset();
      for (int i = 1; i <= 26; i++)
         stepCheck($sformatf("nom w%0d", i), 1'b1, 1'b1, (i == 1), codes[i], (i == 26), 1'b0, (i != 26));
      checkOutput("nom cnt", 32'(frame_cnt), 32'd1);
      for (int i = 1; i <= 5; i++)
         stepCheck($sformatf("pre-rst w%0d", i), 1'b1, 1'b1, (i == 1), codes[i], 1'b0, 1'b0, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async rst state", 32'(frame_state), 32'd0);
      checkOutput("async rst busy",  32'(busy), 32'd0);
      checkOutput("async rst err",   32'(frame_err), 32'd0);
      checkOutput("async rst cnt",   32'(frame_cnt), 32'd0);
      @(negedge clk_390p625M);
      rst_n = 1'b1;
      stepCheck("post-rst nosof", 1'b1, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);

      // Stalls: 3 after word 10, 1 after word 25
      doReset();
      for (int i = 1; i <= 26; i++) begin
         stepCheck($sformatf("stall w%0d", i), 1'b1, 1'b1, (i == 1), codes[i], (i == 26), 1'b0, (i != 26));
         if (i == 10)
            for (int k = 0; k < 3; k++) stepCheck("stall a", 1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1);
         if (i == 25)
            stepCheck("stall b", 1'b1, 1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b1);
      end
      checkOutput("stall cnt", 32'(frame_cnt), 32'd1);

      // Resync: sof on word 14 of an open frame
      doReset();
      for (int i = 1; i <= 13; i++)
         stepCheck($sformatf("resync w%0d", i), 1'b1, 1'b1, (i == 1), codes[i], 1'b0, 1'b0, 1'b1);
      stepCheck("resync sof", 1'b1, 1'b1, 1'b1, 5'b00001, 1'b0, 1'b1, 1'b1);
      for (int i = 2; i <= 26; i++)
         stepCheck($sformatf("resync n%0d", i), 1'b1, 1'b1, 1'b0, codes[i], (i == 26), 1'b0, (i != 26));
      checkOutput("resync cnt", 32'(frame_cnt), 32'd1);

      // Lock loss at word 7 while sof is high
      doReset();
      for (int i = 1; i <= 6; i++)
         stepCheck($sformatf("lock w%0d", i), 1'b1, 1'b1, (i == 1), codes[i], 1'b0, 1'b0, 1'b1);
      stepCheck("lock drop", 1'b0, 1'b1, 1'b1, 5'b00000, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++)
         stepCheck("lock nosof", 1'b1, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);
      stepCheck("lock resof", 1'b1, 1'b1, 1'b1, 5'b00001, 1'b0, 1'b0, 1'b1);

      // Five back-to-back frames with a 2-bit saturating counter
      doReset();
      for (int f = 0; f < 5; f++) begin
         for (int i = 1; i <= 26; i++)
            stepCheck($sformatf("b2b f%0d w%0d", f, i), 1'b1, 1'b1, (i == 1), codes[i], (i == 26), 1'b0, (i != 26));
         checkOutput($sformatf("b2b cnt f%0d", f), 32'(frame_cnt), (f < 2) ? 32'(f + 1) : 32'd3);
      end

      // Four-cycle stall after FRAME5
      doReset();
      for (int i = 1; i <= 5; i++)
         stepCheck($sformatf("wdog w%0d", i), 1'b1, 1'b1, (i == 1), codes[i], 1'b0, 1'b0, 1'b1);
      for (int k = 1; k <= 3; k++)
         stepCheck($sformatf("wdog stall%0d", k), 1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1);
`ifdef FRAME_CTRL_WATCHDOG_EN
      stepCheck("wdog stall4", 1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b1, 1'b0);
      stepCheck("wdog after",  1'b1, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);
`else
      stepCheck("wdog stall4", 1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1);
      stepCheck("wdog after",  1'b1, 1'b1, 1'b0, 5'b00101, 1'b0, 1'b0, 1'b1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
